mem_access_stage: RTL and testbench

Pipeline MEM stage of the 5-stage CPU. Sits between the EX/MEM boundary and the data memory.
- Accepts one load/store/pass-through op per cycle from EX over a valid/ready handshake.
- Drives the data memory's address/data/write-enable port.
- Covers the memory's one-cycle registered read latency and presents the MEM/WB register to writeback.
- When writeback stalls, holds load results stable without an extra data buffer.

---
 rtl/mem_access_stage_if.sv | 46 ++++
 rtl/mem_access_stage.sv | 98 +++++++++
 tb/tb_mem_access_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: bundles the EX-side op handshake, the data memory port,
// the MEM/WB register outputs and the status/counter outputs of the MEM stage.
// Ports: master = environment (EX, data memory, WB); slave = the MEM stage.
interface mem_access_stage_if #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8
);
  // EX -> MEM op handshake
  logic                 ex_valid;
  logic                 ex_ready;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic [DSIZE-1:0]     ex_alu_result;
  logic [DSIZE-1:0]     ex_store_data;
  logic                 ex_reg_write;
  logic [4:0]           ex_rd;
  // data memory port
  logic [MEM_SPACE-1:0] dm_address;
  logic [DSIZE-1:0]     dm_data_in;
  logic                 dm_write_en;
  logic [DSIZE-1:0]     dm_data_out;
  // MEM/WB register
  logic                 wb_valid;
  logic                 wb_ready;
  logic                 wb_reg_write;
  logic [4:0]           wb_rd;
  logic [DSIZE-1:0]     wb_data;
  // status
  logic                 addr_err;
  logic [15:0]          load_count;
  logic [15:0]          store_count;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_alu_result, ex_store_data,
           ex_reg_write, ex_rd, dm_data_out, wb_ready,
    input  ex_ready, dm_address, dm_data_in, dm_write_en, wb_valid,
           wb_reg_write, wb_rd, wb_data, addr_err, load_count, store_count
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_alu_result, ex_store_data,
           ex_reg_write, ex_rd, dm_data_out, wb_ready,
    output ex_ready, dm_address, dm_data_in, dm_write_en, wb_valid,
           wb_reg_write, wb_rd, wb_data, addr_err, load_count, store_count
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage, drives the data memory and holds the MEM/WB register.
// Latency: op accepted at edge E is presented to WB in cycle E+1 (matches 1-cycle memory read).
// Backpressure: ex_ready = !wb_valid || wb_ready; a stalled load keeps its address on the port.
// Ports: clk, rst (async active-low), bus (slave modport: EX handshake, dm port, WB, status).
module mem_access_stage #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_stage_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state_q, state_d;
  logic                 is_load_q;
  logic [DSIZE-1:0]     result_q;
  logic [MEM_SPACE-1:0] addr_q;
  logic [4:0]           rd_q;
  logic                 reg_write_q;
  logic                 addr_err_q;
  logic [15:0]          load_cnt_q;
  logic [15:0]          store_cnt_q;

  logic accept;
  logic range_err;
  logic is_load;
  logic is_store;
  logic write_en;

  assign range_err = |bus.ex_alu_result[DSIZE-1:MEM_SPACE];
  // A load+store encoding is treated as a load.
  assign is_load   = bus.ex_mem_read;
  assign is_store  = bus.ex_mem_write && !bus.ex_mem_read;

  assign bus.ex_ready = (state_q == EMPTY) || bus.wb_ready;
  assign accept       = bus.ex_valid && bus.ex_ready;
  // rst gates the enable so no write can leak out while reset is held.
  assign write_en     = rst && accept && is_store && !range_err;

  // While not accepting, keep re-reading the held address so a stalled
  // load's dm_data_out stays stable without a separate data buffer.
  assign bus.dm_address  = accept ? bus.ex_alu_result[MEM_SPACE-1:0] : addr_q;
  assign bus.dm_data_in  = bus.ex_store_data;
  assign bus.dm_write_en = write_en;

  assign bus.wb_valid     = (state_q == FULL);
  assign bus.wb_reg_write = reg_write_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = is_load_q ? bus.dm_data_out : result_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.load_count   = load_cnt_q;
  assign bus.store_count  = store_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.wb_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_load_q   <= 1'b0;
      result_q    <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      addr_err_q  <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (accept) begin
        is_load_q   <= is_load;
        result_q    <= bus.ex_alu_result;
        addr_q      <= bus.ex_alu_result[MEM_SPACE-1:0];
        rd_q        <= bus.ex_rd;
        // An out-of-range memory op still flows to WB but must not retire a write.
        reg_write_q <= bus.ex_reg_write && !((is_load || is_store) && range_err);
        if ((is_load || is_store) && range_err) addr_err_q <= 1'b1;
        if (is_load && load_cnt_q != 16'hFFFF) load_cnt_q <= load_cnt_q + 16'd1;
      end
      if (write_en && store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized + directed bench with a behavioural data memory
// and a queue-based reference model of the MEM stage.
module tb_mem_access_stage;

  localparam int DSIZE     = 16;
  localparam int MEM_SPACE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_access_stage_if #(.DSIZE(DSIZE), .MEM_SPACE(MEM_SPACE)) bus ();

  mem_access_stage #(.DSIZE(DSIZE), .MEM_SPACE(MEM_SPACE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Behavioural data memory: synchronous write, registered read.
  logic [15:0] dmem [256];
  logic        dmem_init = 1'b0;
  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
      dmem_init <= 1'b1;
    end else begin
      if (bus.dm_write_en) dmem[bus.dm_address] <= bus.dm_data_in;
      bus.dm_data_out <= dmem[bus.dm_address];
    end
  end

  // Reference model state
  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [256];
  int          ref_loads;
  int          ref_stores;
  logic        ref_err;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic mr, input logic mw,
                     input logic [15:0] alu, input logic [15:0] sd,
                     input logic rw, input logic [4:0] rd, input logic wr);
    logic exp_rdy, acc, err, st;
    exp_t e;
    @(negedge clk);
    bus.ex_valid      = v;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_alu_result = alu;
    bus.ex_store_data = sd;
    bus.ex_reg_write  = rw;
    bus.ex_rd         = rd;
    bus.wb_ready      = wr;
    #1;
    exp_rdy = (exp_q.size() == 0) || wr;
    chk("ex_ready", 32'(bus.ex_ready), 32'(exp_rdy));
    chk("wb_valid", 32'(bus.wb_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("wb_rd", 32'(bus.wb_rd), 32'(exp_q[0].rd));
      chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(exp_q[0].rw));
      chk("wb_data", 32'(bus.wb_data), 32'(exp_q[0].data));
    end
    acc = v && exp_rdy;
    err = (mr || mw) && (alu[15:8] != 8'h00);
    st  = mw && !mr;
    chk("dm_write_en", 32'(bus.dm_write_en), 32'(acc && st && !err));
    if (acc) chk("dm_address", 32'(bus.dm_address), 32'(alu[7:0]));
    if (acc && st) chk("dm_data_in", 32'(bus.dm_data_in), 32'(sd));
    chk("load_count", 32'(bus.load_count), 32'(ref_loads));
    chk("store_count", 32'(bus.store_count), 32'(ref_stores));
    chk("addr_err", 32'(bus.addr_err), 32'(ref_err));

    if (exp_q.size() != 0 && wr) void'(exp_q.pop_front());
    if (acc) begin
      e.rd   = rd;
      e.rw   = rw && !err;
      e.data = mr ? ref_mem[alu[7:0]] : alu;
      exp_q.push_back(e);
      if (mr) ref_loads = (ref_loads < 65535) ? ref_loads + 1 : 65535;
      if (st && !err) begin
        ref_mem[alu[7:0]] = sd;
        ref_stores = (ref_stores < 65535) ? ref_stores + 1 : 65535;
      end
      if (err) ref_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b0;
    bus.ex_valid      = 1'b1;
    bus.ex_mem_write  = 1'b1;
    bus.ex_mem_read   = 1'b0;
    bus.ex_alu_result = 16'h0003;
    bus.wb_ready      = 1'b0;
    #1;
    chk("rst_dm_write_en", 32'(bus.dm_write_en), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_load_count", 32'(bus.load_count), 32'd0);
    chk("rst_store_count", 32'(bus.store_count), 32'd0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst_wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_hold_dm_write_en", 32'(bus.dm_write_en), 32'd0);
    exp_q.delete();
    ref_loads  = 0;
    ref_stores = 0;
    ref_err    = 1'b0;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    rst          = 1'b1;
  endtask

  initial begin
    logic [15:0] alu;
    logic        mr, mw;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    ref_loads  = 0;
    ref_stores = 0;
    ref_err    = 1'b0;
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b1;
    bus.ex_alu_result = '0;
    bus.ex_store_data = '0;
    bus.ex_reg_write  = 1'b0;
    bus.ex_rd         = '0;
    bus.wb_ready      = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Store then load the same address
    cyc(1, 0, 1, 16'h0010, 16'hBEEF, 0, 5'd0, 1);
    cyc(1, 1, 0, 16'h0010, 16'h0000, 1, 5'd3, 1);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 5'd0, 1);
    // Back-to-back loads
    cyc(1, 1, 0, 16'h0000, 16'h0000, 1, 5'd1, 1);
    cyc(1, 1, 0, 16'h0001, 16'h0000, 1, 5'd2, 1);
    cyc(1, 1, 0, 16'h0002, 16'h0000, 1, 5'd4, 1);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 5'd0, 1);
    // Stall: load held for 3 cycles while a store waits, then release
    cyc(1, 1, 0, 16'h0007, 16'h0000, 1, 5'd9, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 16'h0007, 16'h1111, 0, 5'd0, 0);
    cyc(1, 0, 1, 16'h0007, 16'h1111, 0, 5'd0, 1);
    cyc(1, 1, 0, 16'h0007, 16'h0000, 1, 5'd10, 1);
    // Address error store, then pass-through ALU op
    cyc(1, 0, 1, 16'h0100, 16'hDEAD, 1, 5'd6, 1);
    cyc(1, 0, 0, 16'h1234, 16'h0000, 1, 5'd5, 1);
    cyc(1, 1, 0, 16'h0000, 16'h0000, 1, 5'd7, 1);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 5'd0, 1);

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      alu = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) alu = 16'($urandom);
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 2) == 0);
      cyc(($urandom_range(0, 3) != 0), mr, mw, alu, 16'($urandom),
          1'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
    end
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 5'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
